// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and widths for the FIFO write-port arbiter.
// Optional write counter enabled by FIFO_WR_ARB_CNT_EN (see fifo_wr_arbiter).
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int BURST_CNT_W = 8;
  localparam int WR_CNT_W    = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: rotate the request vector so the slot after
// last_owner sits at bit 0, priority-encode, then map the index back.
module rr_picker #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last_owner,
  output logic [$clog2(NREQ)-1:0] next_idx,
  output logic                    valid
);

  localparam int IDX_W = $clog2(NREQ);

  logic [IDX_W-1:0] start_s;
  logic [NREQ-1:0]  rot_s;
  logic [IDX_W:0]   enc_s;
  logic [IDX_W:0]   sum_s;

  // Rotate, priority-encode the lowest set bit, then un-rotate modulo NREQ.
  always_comb begin
    start_s = '0;
    rot_s   = '0;
    enc_s   = '0;
    sum_s   = '0;
    if (last_owner == IDX_W'(NREQ - 1)) begin
      start_s = '0;
    end else begin
      start_s = last_owner + IDX_W'(1);
    end
    for (int i = 0; i < NREQ; i++) begin
      int src;
      src = i + int'(start_s);
      if (src >= NREQ) begin
        src = src - NREQ;
      end else begin
        src = src;
      end
      rot_s[i] = req[src];
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      enc_s = rot_s[i] ? (IDX_W+1)'(i) : enc_s;
    end
    sum_s = enc_s + {1'b0, start_s};
    if (sum_s >= (IDX_W+1)'(NREQ)) begin
      sum_s = sum_s - (IDX_W+1)'(NREQ);
    end else begin
      sum_s = sum_s;
    end
    next_idx = sum_s[IDX_W-1:0];
    valid    = |req;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NREQ requesters with bounded bursts.
// Define FIFO_WR_ARB_CNT_EN to add the 16-bit wr_count output of accepted writes.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                         wclk,
  input  logic                         wrst_n,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ*DATA_WIDTH-1:0]   req_data,
  input  logic                         full,
  output logic [NREQ-1:0]              ack,
  output logic                         w_en,
  output logic [DATA_WIDTH-1:0]        wdata,
  output logic [$clog2(NREQ)-1:0]      owner,
  output logic                         busy
`ifdef FIFO_WR_ARB_CNT_EN
  ,
  output logic [WR_CNT_W-1:0]          wr_count
`endif
);

  localparam int IDX_W = $clog2(NREQ);

  arb_state_t             state_q, state_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       last_owner_q, last_owner_d;
  logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic             pick_valid_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic             req_own_s;
  logic             accept_s;
  logic             last_beat_s;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req        (req),
    .last_owner (last_owner_q),
    .next_idx   (pick_idx_s),
    .valid      (pick_valid_s)
  );

  // Write-port outputs follow the registered grant so reset removes them at once.
  always_comb begin
    req_own_s   = req[owner_q];
    w_en        = 1'b0;
    wdata       = '0;
    ack         = '0;
    if (state_q == BURST) begin
      w_en  = req_own_s;
      wdata = req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      w_en  = 1'b0;
      wdata = '0;
    end
    accept_s    = w_en & ~full;
    last_beat_s = (burst_cnt_q == BURST_CNT_W'(MAX_BURST - 1));
    if (accept_s) begin
      ack[owner_q] = 1'b1;
    end else begin
      ack = '0;
    end
    owner = owner_q;
    busy  = (state_q == BURST);
  end

  // Grant sequencing; a held word under full keeps both the grant and the count.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid_s) begin
          state_d     = BURST;
          owner_d     = pick_idx_s;
          burst_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      BURST: begin
        if (!req_own_s || (accept_s && last_beat_s)) begin
          state_d      = IDLE;
          last_owner_d = owner_q;
        end else if (accept_s) begin
          burst_cnt_d = burst_cnt_q + BURST_CNT_W'(1);
        end else begin
          burst_cnt_d = burst_cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Arbiter state registers; last_owner resets so requester 0 wins first.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= IDX_W'(NREQ - 1);
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

`ifdef FIFO_WR_ARB_CNT_EN
  logic [WR_CNT_W-1:0] wr_count_q, wr_count_d;

  // Free-running count of accepted writes, wrapping at the counter width.
  always_comb begin
    if (accept_s) begin
      wr_count_d = wr_count_q + WR_CNT_W'(1);
    end else begin
      wr_count_d = wr_count_q;
    end
  end

  // Accepted-write counter register.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wr_count_q <= '0;
    end else begin
      wr_count_q <= wr_count_d;
    end
  end

  assign wr_count = wr_count_q;
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of the asynchronous FIFO's write domain among NREQ requesters. It sits in the wclk domain in front of the FIFO write side and drives its w_en and write data. It observes the FIFO's registered full flag so that every write it presents is either accepted or held. Bounded bursts keep one requester from monopolising the port.

## Interface
- NREQ, 4: number of requesters, 2..16.
- DATA_WIDTH, 8: FIFO data width.
- MAX_BURST, 4: maximum accepted writes per grant, 1..255.
- IDX_W, $clog2(NREQ): derived localparam, not overridable.

Ports:
- wclk  in  1  write-domain clock; all state on rising edge.
- wrst_n  in  1  asynchronous active-low reset, asserted asynchronously, deasserted synchronously to wclk upstream.
- req  in  NREQ  per-requester write request; held high with data stable until ack.
- req_data  in  NREQ*DATA_WIDTH  packed write data; slice i belongs to requester i.
- full  in  1  registered full flag from the FIFO write pointer logic.
- ack  out  NREQ  one-hot; ack[i]=1 means requester i's word is written at this edge.
- w_en  out  1  FIFO write enable.
- wdata  out  DATA_WIDTH  FIFO write data.
- owner  out  IDX_W  index of the current grant holder; valid while busy.
- busy  out  1  high in the BURST state.

## Operation
- States:
  - IDLE: no grant.
  - BURST: owner holds the port.
- Registers: state, owner, last_owner, burst_cnt (8 bits).
- Combinational outputs:
  - w_en = (state==BURST) & req[owner].
  - wdata = req_data slice[owner]; 0 when state is IDLE.
  - accept = w_en & ~full. This is the same condition the FIFO uses to advance its pointer.
  - ack[owner] = accept; all other ack bits are 0.
- IDLE with |req=1: pick the first set req scanning from last_owner+1 upward, wrapping modulo NREQ. Load owner, clear burst_cnt, go to BURST.
- IDLE with req=0: stay in IDLE.
- BURST exits to IDLE and sets last_owner=owner when either:
  - accept and burst_cnt==MAX_BURST-1, or
  - req[owner]=0.
- BURST with accept and no exit: burst_cnt increments.
- BURST with full=1: w_en stays high, there is no accept, burst_cnt holds, and the grant is kept. There is no timeout.
- Requester rule: req[i] may drop only in the cycle after ack[i]. The arbiter does not check this rule.

## Timing
- Reset values:
  - state=IDLE, owner=0, last_owner=NREQ-1 (so requester 0 has first priority), burst_cnt=0.
  - w_en=0, wdata=0, ack=0, busy=0, owner output=0.
- Latency: req rising in IDLE → w_en one cycle later. Arbitration costs exactly one IDLE cycle per grant change.
- Full throughput within a burst: one word per cycle while req is held and full=0.
- After MAX_BURST accepts, there is one IDLE cycle before the next grant, including a re-grant to the same requester.
- Full rising in the same cycle as w_en: no accept, and the word is retried every cycle until full falls.
- req[owner] dropping while full=1 violates the protocol. The arbiter still exits to IDLE without writing.
- Reset asserted mid-burst: all outputs return to reset values immediately. There is no partial write, because w_en drops asynchronously with state.
- burst_cnt never exceeds MAX_BURST-1.

## Configuration
- FIFO_WR_ARB_CNT_EN defined:
  - Adds output wr_count (16 bits), the number of accepted writes.
  - Resets to 0, increments on accept, wraps from 0xFFFF to 0.
- FIFO_WR_ARB_CNT_EN undefined: the port and counter are absent. Behaviour is otherwise identical.

## Structure
- Package fifo_arb_pkg holds:
  - arb_state_t enum (IDLE, BURST).
  - Burst counter width constant (8).
  - wr_count width constant (16).
- Sub-module rr_picker: purely combinational.
  - Inputs: req vector and last_owner.
  - Outputs: next index and valid.
  - Implemented as a rotate, then priority-encode, then un-rotate.

## Test plan
- Reset, then req=4'b0001 with data 0xA5 held two cycles → w_en high in cycle 2, wdata=0xA5, ack[0] pulses; req drop → IDLE.
- All four req high continuously, MAX_BURST=4, full=0 → grants 0,1,2,3,0 in order; 4 acks per grant; one idle cycle between grants.
- Requester 2 streaming; full forced high for 5 cycles mid-burst → w_en held, no ack, burst_cnt frozen; resumes at full fall; total acks still 4.
- Requesters 1 and 3 high, last_owner=1 → owner=3 is selected next, then 1 (wrap check).
- wrst_n asserted while w_en=1 mid-burst → w_en, ack, busy are 0 in the same cycle; after release, requester 0 has priority.
- With FIFO_WR_ARB_CNT_EN: 70000 accepted writes → wr_count=70000 mod 65536=4464.
